// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the twelve bus masters and bus_rr_arbiter.
interface bus_rr_arbiter_if;
    logic [11:0] m_reqs;
    logic        bus_util;
    logic [11:0] m_grants;
    logic [3:0]  mid_current;
    logic [2:0]  state;
    logic        timeout;

    // master: the requesting side; slave: the arbiter itself
    modport master (output m_reqs, bus_util, input m_grants, mid_current, state, timeout);
    modport slave  (input m_reqs, bus_util, output m_grants, mid_current, state, timeout);
endinterface

// File: rtl/bus_rr_arbiter.sv
// Twelve-master bus arbiter: fixed group priority P1>P2>P3, round-robin within each group.
// Define ARB_AGING_EN to compile in starvation aging that promotes groups P2/P3 over P1.
module bus_rr_arbiter #(
    parameter int unsigned GRANT_TIMEOUT = 8,
    parameter int unsigned AGE_LIMIT     = 15
) (
    input  logic            clk,
    input  logic            rst,
    bus_rr_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        GRANT   = 3'd2,
        OWNED   = 3'd3,
        RELEASE = 3'd4
    } state_e;

    localparam logic [3:0] MID_NONE  = 4'hF;
    localparam logic [7:0] WAIT_LAST = 8'(GRANT_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [11:0]     req_snap;   // requests frozen on the last IDLE cycle, arbitrated in ARB
    logic [2:0][1:0] ptr_q;      // per-group index where the next search starts
    logic [7:0]      wait_q, wait_d;
    logic [11:0]     grants_q, grants_d;
    logic [3:0]      mid_q, mid_d;
    logic            timeout_q, timeout_d;

    logic [2:0] grp_req;
    logic [1:0] win_grp, win_idx, grp_ptr;
    logic [3:0] grp_reqs, win_mid;
    logic       held_req, wait_done;
    logic       aged2, aged3;

    function automatic logic [1:0] rr_pick(input logic [3:0] reqs, input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (reqs[idx]) rr_pick = idx;
        end
    endfunction

    assign grp_req   = {|req_snap[11:8], |req_snap[7:4], |req_snap[3:0]};
    assign held_req  = |(bus.m_reqs & grants_q);
    assign wait_done = (wait_q == WAIT_LAST);

`ifdef ARB_AGING_EN
    localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);
    logic [7:0] age2_q, age3_q;

    assign aged2 = grp_req[1] && (age2_q == AGE_MAX);
    assign aged3 = grp_req[2] && (age3_q == AGE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            age2_q <= '0;
            age3_q <= '0;
        end else if (state_q == ARB) begin
            if (win_grp == 2'd1)                        age2_q <= '0;
            else if (grp_req[1] && age2_q != AGE_MAX)   age2_q <= age2_q + 8'd1;
            if (win_grp == 2'd2)                        age3_q <= '0;
            else if (grp_req[2] && age3_q != AGE_MAX)   age3_q <= age3_q + 8'd1;
        end
    end
`else
    logic [31:0] unused_age_limit;
    assign unused_age_limit = AGE_LIMIT;
    assign aged2 = 1'b0;
    assign aged3 = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_grp  = 2'd0;
        grp_reqs = req_snap[3:0];
        grp_ptr  = ptr_q[0];
        if (aged2)           win_grp = 2'd1;
        else if (aged3)      win_grp = 2'd2;
        else if (grp_req[0]) win_grp = 2'd0;
        else if (grp_req[1]) win_grp = 2'd1;
        else if (grp_req[2]) win_grp = 2'd2;
        case (win_grp)
            2'd1: begin grp_reqs = req_snap[7:4];  grp_ptr = ptr_q[1]; end
            2'd2: begin grp_reqs = req_snap[11:8]; grp_ptr = ptr_q[2]; end
            default: ;
        endcase
        win_idx = rr_pick(grp_reqs, grp_ptr);
    end

    assign win_mid = {win_grp, win_idx};

    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.bus_util && |bus.m_reqs) state_d = ARB;
            ARB:     state_d = GRANT;
            GRANT: begin
                if (bus.bus_util)               state_d = OWNED;
                else if (!held_req || wait_done) state_d = IDLE;
            end
            OWNED:   if (!bus.bus_util) state_d = RELEASE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grants_d  = grants_q;
        mid_d     = mid_q;
        timeout_d = 1'b0;
        wait_d    = wait_q;
        case (state_q)
            ARB: begin
                grants_d = 12'd1 << win_mid;
                mid_d    = win_mid;
                wait_d   = '0;
            end
            GRANT: begin
                wait_d = wait_q + 8'd1;
                if (!bus.bus_util && (!held_req || wait_done)) begin
                    grants_d  = '0;
                    mid_d     = MID_NONE;
                    timeout_d = held_req;   // a dropped request withdraws quietly
                end
            end
            OWNED: begin
                if (!bus.bus_util) begin
                    grants_d = '0;
                    mid_d    = MID_NONE;
                end
            end
            default: begin
                grants_d = '0;
                mid_d    = MID_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grants_q  <= '0;
            mid_q     <= MID_NONE;
            timeout_q <= 1'b0;
            wait_q    <= '0;
            req_snap  <= '0;
            ptr_q     <= '0;
        end else begin
            grants_q  <= grants_d;
            mid_q     <= mid_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
            if (state_q == IDLE) req_snap <= bus.m_reqs;
            if (state_q == ARB) begin
                case (win_grp)
                    2'd1:    ptr_q[1] <= win_idx + 2'd1;
                    2'd2:    ptr_q[2] <= win_idx + 2'd1;
                    default: ptr_q[0] <= win_idx + 2'd1;
                endcase
            end
        end
    end

    assign bus.m_grants    = grants_q;
    assign bus.mid_current = mid_q;
    assign bus.state       = state_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_bus_rr_arbiter;
    localparam int unsigned TIMEOUT_CYC = 8;
    localparam int unsigned AGE_LIM     = 3;
    localparam logic [2:0] S_IDLE = 3'd0, S_ARB = 3'd1, S_GRANT = 3'd2, S_OWNED = 3'd3, S_RELEASE = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bus_rr_arbiter_if bus();

    bus_rr_arbiter #(.GRANT_TIMEOUT(TIMEOUT_CYC), .AGE_LIMIT(AGE_LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [2:0]  m_state   = S_IDLE;
    logic [11:0] m_grants  = '0;
    logic [3:0]  m_mid     = 4'hF;
    logic        m_timeout = 1'b0;
    logic [11:0] m_snap    = '0;
    int          m_ptr[3]  = '{0, 0, 0};
    int          m_age[3]  = '{0, 0, 0};
    int          m_wait    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit grp_has(input logic [11:0] r, input int g);
        return ((r >> (4 * g)) & 12'hF) != 12'h0;
    endfunction

    task automatic model_clear();
        m_grants = '0;
        m_mid    = 4'hF;
        m_state  = S_IDLE;
    endtask

    task automatic model_step(input logic [11:0] r, input logic u, input logic rs);
        int grp;
        int idx;
        int pos;
        if (rs) begin
            model_clear();
            m_timeout = 1'b0;
            m_snap    = '0;
            m_wait    = 0;
            for (int g = 0; g < 3; g++) begin
                m_ptr[g] = 0;
                m_age[g] = 0;
            end
        end else begin
            m_timeout = 1'b0;
            case (m_state)
                S_IDLE: begin
                    if (!u && r != 12'h0) begin
                        m_snap  = r;
                        m_state = S_ARB;
                    end
                end
                S_ARB: begin
                    grp = -1;
`ifdef ARB_AGING_EN
                    if (m_age[1] == int'(AGE_LIM) && grp_has(m_snap, 1))      grp = 1;
                    else if (m_age[2] == int'(AGE_LIM) && grp_has(m_snap, 2)) grp = 2;
`endif
                    for (int g = 0; g < 3; g++)
                        if (grp < 0 && grp_has(m_snap, g)) grp = g;
                    idx = -1;
                    for (int k = 0; k < 4; k++) begin
                        pos = (m_ptr[grp] + k) % 4;
                        if (idx < 0 && m_snap[grp * 4 + pos]) idx = pos;
                    end
                    m_ptr[grp] = (idx + 1) % 4;
                    for (int g = 1; g < 3; g++) begin
                        if (g == grp) m_age[g] = 0;
                        else if (grp_has(m_snap, g) && m_age[g] < int'(AGE_LIM)) m_age[g]++;
                    end
                    m_mid    = 4'(grp * 4 + idx);
                    m_grants = 12'd1 << (grp * 4 + idx);
                    m_wait   = 0;
                    m_state  = S_GRANT;
                end
                S_GRANT: begin
                    if (u) m_state = S_OWNED;
                    else if ((r & m_grants) == 12'h0) model_clear();
                    else begin
                        m_wait++;
                        if (m_wait == int'(TIMEOUT_CYC)) begin
                            model_clear();
                            m_timeout = 1'b1;
                        end
                    end
                end
                S_OWNED: begin
                    if (!u) begin
                        model_clear();
                        m_state = S_RELEASE;
                    end
                end
                default: m_state = S_IDLE;
            endcase
        end
    endtask

    task automatic cycle(input logic [11:0] r, input logic u, input logic rs);
        bus.m_reqs   = r;
        bus.bus_util = u;
        rst          = rs;
        @(posedge clk);
        model_step(r, u, rs);
        #1;
        check("state",       32'(bus.state),       32'(m_state));
        check("m_grants",    32'(bus.m_grants),    32'(m_grants));
        check("mid_current", 32'(bus.mid_current), 32'(m_mid));
        check("timeout",     32'(bus.timeout),     32'(m_timeout));
    endtask

    task automatic do_reset();
        cycle(12'h0, 1'b0, 1'b1);
    endtask

    task automatic complete_grant(input logic [11:0] r, output logic [3:0] mid);
        int n = 0;
        while (m_state != S_GRANT && n < 20) begin
            cycle(r, 1'b0, 1'b0);
            n++;
        end
        check("grant_reached", 32'(bus.state), 32'(S_GRANT));
        mid = bus.mid_current;
        cycle(r, 1'b1, 1'b0);
        cycle(r, 1'b0, 1'b0);
        cycle(r, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  mid;
        logic [11:0] r;
        int          n;
        logic [3:0]  exp_rr[5]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
`ifdef ARB_AGING_EN
        logic [3:0]  exp_age[5] = '{4'd0, 4'd0, 4'd0, 4'd8, 4'd0};
`else
        logic [3:0]  exp_age[5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
`endif
        bus.m_reqs   = '0;
        bus.bus_util = 1'b0;

        do_reset();
        do_reset();
        check("rst_state",   32'(bus.state),       32'(S_IDLE));
        check("rst_grants",  32'(bus.m_grants),    32'h0);
        check("rst_mid",     32'(bus.mid_current), 32'hF);
        check("rst_timeout", 32'(bus.timeout),     32'h0);

        // single request, full ownership cycle
        cycle(12'h001, 1'b0, 1'b0);
        check("s1_arb", 32'(bus.state), 32'(S_ARB));
        cycle(12'h001, 1'b0, 1'b0);
        check("s1_grant", 32'(bus.m_grants), 32'h001);
        cycle(12'h001, 1'b1, 1'b0);
        check("s1_owned", 32'(bus.state), 32'(S_OWNED));
        cycle(12'h001, 1'b0, 1'b0);
        check("s1_release", 32'(bus.state), 32'(S_RELEASE));
        check("s1_rel_grants", 32'(bus.m_grants), 32'h0);
        cycle(12'h000, 1'b0, 1'b0);
        check("s1_idle", 32'(bus.state), 32'(S_IDLE));

        // round-robin inside P1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            complete_grant(12'h00F, mid);
            check("rr_order", 32'(mid), 32'(exp_rr[i]));
        end

        // unused grant times out
        do_reset();
        cycle(12'h020, 1'b0, 1'b0);
        cycle(12'h020, 1'b0, 1'b0);
        check("to_granted", 32'(bus.m_grants), 32'h020);
        n = 0;
        do begin
            cycle(12'h020, 1'b0, 1'b0);
            n++;
        end while (bus.timeout !== 1'b1 && n < 12);
        check("to_latency", 32'(n), 32'd8);
        check("to_grants", 32'(bus.m_grants), 32'h0);
        check("to_state", 32'(bus.state), 32'(S_IDLE));
        cycle(12'h020, 1'b0, 1'b0);
        check("to_rearb", 32'(bus.state), 32'(S_ARB));
        check("to_pulse_end", 32'(bus.timeout), 32'h0);

        // starving P3 against P1 (aging promotes master 8 only when compiled in)
        do_reset();
        for (int i = 0; i < 5; i++) begin
            complete_grant(12'h101, mid);
            check("age_order", 32'(mid), 32'(exp_age[i]));
        end

        // reset while a master owns the bus
        do_reset();
        cycle(12'h020, 1'b0, 1'b0);
        cycle(12'h020, 1'b0, 1'b0);
        cycle(12'h020, 1'b1, 1'b0);
        check("own_state", 32'(bus.state), 32'(S_OWNED));
        check("own_mid", 32'(bus.mid_current), 32'd5);
        cycle(12'h020, 1'b1, 1'b1);
        check("rst_own_state", 32'(bus.state), 32'(S_IDLE));
        check("rst_own_mid", 32'(bus.mid_current), 32'hF);
        check("rst_own_grants", 32'(bus.m_grants), 32'h0);

        // randomized traffic
        do_reset();
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0:       r = 12'($urandom);
                    1:       r = 12'd1 << $urandom_range(0, 11);
                    2:       r = 12'($urandom) & 12'hFF0;
                    3:       r = 12'($urandom) & 12'hF0F;
                    default: r = '0;
                endcase
            end
            cycle(r, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter GRANT_TIMEOUT, default 8: cycles a grant waits for bus_util before it is withdrawn (legal range 1-255).
REQ-002 Parameter AGE_LIMIT, default 15: lost arbitrations before a starving group is promoted (legal range 1-255).
REQ-003 clk  input  1  sole clock; all state updates on the posedge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 m_reqs  input  12  master requests; bits 3:0 are group P1, 7:4 are P2, 11:8 are P3.
REQ-006 bus_util  input  1  bus-in-use indication from the current bus owner.
REQ-007 m_grants  output  12  one-hot grant, registered.
REQ-008 mid_current  output  4  ID of the granted or owning master; 4'b1111 means none.
REQ-009 state  output  3  current FSM state encoding.
REQ-010 timeout  output  1  one-cycle pulse when a grant is withdrawn unused.

Function
REQ-011 States SHALL be IDLE=0, ARB=1, GRANT=2, OWNED=3, RELEASE=4; no other encodings are reachable.
REQ-012 IDLE SHALL go to ARB when bus_util=0 and any m_reqs bit=1, and SHALL otherwise stay in IDLE.
REQ-013 ARB SHALL last one cycle: it registers the winner into mid_current and m_grants, then enters GRANT.
REQ-014 Latency: a request sampled at posedge k in IDLE SHALL produce the grant visible after posedge k+1.
REQ-015 Group priority SHALL be fixed at P1 > P2 > P3, except where REQ-018 applies.
REQ-016 Within a group, round-robin SHALL apply: search starts at the index after the group's last winner and wraps 3->0.
REQ-017 Each group pointer SHALL update only when that group wins ARB.
REQ-018 With aging enabled:
- P2 and P3 each keep an age counter.
- A counter increments when its group had a request in ARB but lost.
- A counter saturates at AGE_LIMIT.
- A group with age==AGE_LIMIT SHALL win ARB over P1.
- If both P2 and P3 are aged, P2 SHALL win.
- The winning group's age SHALL clear to 0.
REQ-019 In GRANT, the grant is held and a wait counter counts from 0:
- bus_util=1 goes to OWNED.
- The granted m_reqs bit dropping (with bus_util=0) goes to IDLE, clears the grant, and asserts no timeout.
- The counter reaching GRANT_TIMEOUT clears the grant, pulses timeout for one cycle, and goes to IDLE.
REQ-020 If bus_util=1 and the request drops in the same GRANT cycle, bus_util SHALL take priority (go to OWNED).
REQ-021 In a timeout, the round-robin pointer SHALL stay advanced, so a dead master cannot re-win ahead of its peers.
REQ-022 OWNED SHALL hold m_grants and mid_current while bus_util=1; bus_util=0 goes to RELEASE.
REQ-023 RELEASE SHALL clear m_grants to 0 and mid_current to 4'b1111, then go to IDLE after exactly one cycle.
REQ-024 m_grants SHALL always be zero or one-hot, and SHALL match mid_current whenever it is nonzero.
REQ-025 Requests changing during ARB, OWNED or RELEASE SHALL NOT affect the current owner.

Reset
REQ-026 rst=1 at a posedge SHALL force the following, overriding any state including mid-grant or OWNED:
- state=IDLE, m_grants=0, mid_current=4'b1111, timeout=0;
- all pointers=0, all ages=0, wait counter=0.
REQ-027 The first arbitration after reset SHALL search each group starting from index 0.

Configuration
REQ-028 Macro ARB_AGING_EN:
- When defined, the age counters and the REQ-018 promotion are compiled in.
- When undefined, no age counters exist, arbitration is strict P1>P2>P3 with round-robin within each group, and AGE_LIMIT is ignored.

Verification
REQ-029 Scenario: m_reqs=12'h001, bus_util=0 from reset -> m_grants=12'h001 two edges after the request; raise bus_util -> state=OWNED; drop bus_util -> RELEASE, then IDLE, m_grants=0.
REQ-030 Scenario: m_reqs=12'h00F held, each grant completed -> grant order 0,1,2,3,0.
REQ-031 Scenario: m_reqs=12'h020, bus_util never rises -> timeout pulses once 8 cycles after the grant, m_grants=0, state returns to IDLE and re-arbitrates.
REQ-032 Scenario (ARB_AGING_EN, AGE_LIMIT=3): m_reqs=12'h101 held -> master 0 wins 3 times, then master 8 wins once, then master 0 again.
REQ-033 Scenario: same stimulus as REQ-032 without ARB_AGING_EN -> master 8 never granted.
REQ-034 Scenario: rst=1 asserted while in OWNED with mid_current=5 -> next cycle state=IDLE, mid_current=4'hF, m_grants=0.
